ddr_wr_arbiter: RTL and testbench
=================================

// Module: ddr_wr_arbiter
// PURPOSE
// Two-requester round-robin arbiter in front of ddr_wrap's write port (wstart/wready/waddr/wdata_len/wdata_vld/wdata).
// Shares the single DDR4 S2MM write channel between requesters, e.g. the eth rx path and test_data_gen.
// Each burst is granted whole: command issue, beat forwarding and beat counting.
// A watchdog zero-pads stalled bursts so ddr_wrap never hangs waiting for data.
// PARAMETERS
// DATA_WIDTH   64    write data width, one beat = one wdata word
// ADDR_WIDTH   32    byte address width
// LEN_WIDTH    16    burst length width, counted in beats
// TIMEOUT_CYC  1024  max idle cycles between beats in DATA before padding starts (>=2)
// PORTS
// clk          in   1           system clock (clk_200m domain)
// rst          in   1           asynchronous, active-high reset
// reqN         in   1           N=0,1: burst request, level, held until doneN
// reqN_addr    in   ADDR_WIDTH  burst start address, stable while reqN=1
// reqN_len     in   LEN_WIDTH   burst length in beats, stable while reqN=1
// reqN_gnt     out  1           requester N owns the write channel
// reqN_dvld    in   1           data beat valid; counted only while reqN_gnt=1
// reqN_data    in   DATA_WIDTH  data beat
// reqN_done    out  1           one-cycle pulse: burst N finished (normal, padded or zero-length)
// wstart       out  1           one-cycle command strobe to ddr_wrap
// wready       in   1           ddr_wrap can accept a new command
// waddr        out  ADDR_WIDTH  command address, held from wstart until next wstart
// wdata_len    out  LEN_WIDTH   command length in beats, held like waddr
// wdata_vld    out  1           beat valid to ddr_wrap
// wdata        out  DATA_WIDTH  beat data to ddr_wrap
// abort        out  1           one-cycle pulse: watchdog fired, padding started
// BEHAVIOUR
// Reset: all outputs 0; state IDLE; rr pointer favours req0; beat and watchdog counters cleared.
// All outputs are registered.
// FSM: IDLE -> START -> DATA -> IDLE, with DATA -> PAD -> IDLE on timeout.
// IDLE:
//   Arbitrate only when wready=1 and at least one reqN=1.
//   Both requesting: grant the requester not served last; single request: grant it.
//   Latch owner, addr and len.
//   If len==0: pulse reqN_done next cycle, no wstart, pointer advances, stay IDLE.
//   Otherwise go to START.
// START:
//   wstart=1 for exactly one cycle, with waddr/wdata_len valid.
//   reqN_gnt rises in the same cycle and stays high through DATA/PAD.
//   Next state: DATA.
// DATA:
//   A beat is accepted on a cycle with owner dvld=1 and gnt=1.
//   Accepted beat appears at wdata_vld/wdata the following cycle (latency 1).
//   Non-owner dvld is ignored.
//   Beat counter increments per accepted beat.
//   On the beat that makes count==len:
//     - gnt drops next cycle, reqN_done pulses next cycle, pointer advances;
//     - go to IDLE.
//   Beats presented after the last beat are not forwarded.
// Watchdog:
//   Counts consecutive DATA cycles without an accepted beat; reset by each accepted beat.
//   At TIMEOUT_CYC: pulse abort, drop gnt, go to PAD.
// PAD:
//   Emit (len - count) beats of wdata=0, wdata_vld=1, back-to-back.
//   Then pulse reqN_done, advance pointer, go to IDLE.
// Min one IDLE cycle between bursts; a new wstart is never issued while wready=0.
// Counters are LEN_WIDTH wide, compare-equal, no wrap (len<=2^LEN_WIDTH-1).
// Reset mid-burst: immediate return to IDLE, all outputs 0, and no done pulse.
// TESTING
// 1. req0 addr=0x100 len=4, dvld 4 consecutive cycles ->
//    one wstart, waddr=0x100, wdata_len=4; 4 wdata_vld beats each 1 cycle after dvld;
//    done0 pulse after 4th; gnt0 low after.
// 2. req0 & req1 both asserted from reset, len=2 each ->
//    req0 served first, then req1.
//    Re-assert both: req0 served first again (pointer after req1).
//    Never two grants high.
// 3. req1 len=0 -> done1 pulse within 2 cycles, no wstart, no wdata_vld.
//    Following simultaneous request grants req0.
// 4. Owner req0 len=3, dvld gapped (1,0,0,1,1); req1_dvld toggling throughout ->
//    exactly 3 forwarded beats, all req0 data; wready held 0 in IDLE delays wstart until wready=1.
// 5. TIMEOUT_CYC=16, req1 len=8, 3 beats then dvld=0 -> abort pulse 16 cycles after 3rd beat;
//    5 zero beats back-to-back; then done1; total wdata_vld=8.
// 6. rst pulsed after 2 of 6 beats -> all outputs 0 immediately.
//    No done pulse; fresh request after reset issues a clean wstart.

Source files
------------

// File: rtl/ddr_wr_arbiter.sv
// Two-requester round-robin arbiter for the ddr_wrap write port: grants whole bursts,
// forwards beats with one cycle of latency and zero-pads bursts that stall too long.
module ddr_wr_arbiter #(
    parameter int DATA_WIDTH  = 64,
    parameter int ADDR_WIDTH  = 32,
    parameter int LEN_WIDTH   = 16,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req0,
    input  logic [ADDR_WIDTH-1:0] req0_addr,
    input  logic [LEN_WIDTH-1:0]  req0_len,
    output logic                  req0_gnt,
    input  logic                  req0_dvld,
    input  logic [DATA_WIDTH-1:0] req0_data,
    output logic                  req0_done,
    input  logic                  req1,
    input  logic [ADDR_WIDTH-1:0] req1_addr,
    input  logic [LEN_WIDTH-1:0]  req1_len,
    output logic                  req1_gnt,
    input  logic                  req1_dvld,
    input  logic [DATA_WIDTH-1:0] req1_data,
    output logic                  req1_done,
    output logic                  wstart,
    input  logic                  wready,
    output logic [ADDR_WIDTH-1:0] waddr,
    output logic [LEN_WIDTH-1:0]  wdata_len,
    output logic                  wdata_vld,
    output logic [DATA_WIDTH-1:0] wdata,
    output logic                  abort,
    output logic [1:0]            dbg_state
);

    localparam int WD_W = $clog2(TIMEOUT_CYC + 1);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYC - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_PAD   = 2'd3
    } state_t;

    state_t state_q, state_d;

    logic                  owner_q;
    logic                  last_q;
    logic [LEN_WIDTH-1:0]  len_q;
    logic [LEN_WIDTH-1:0]  cnt_q;
    logic [WD_W-1:0]       wd_q;

    logic                  arb_fire;
    logic                  arb_pick;
    logic [LEN_WIDTH-1:0]  pick_len;
    logic [ADDR_WIDTH-1:0] pick_addr;
    logic                  own_dvld;
    logic [DATA_WIDTH-1:0] own_data;
    logic                  accept;
    logic [LEN_WIDTH-1:0]  cnt_inc;
    logic                  last_beat;
    logic                  timeout;
    logic                  pad_last;

    // Beat handshake: a beat transfers on every cycle where the owner's dvld is high while
    // its gnt is high; there is no back-pressure, and gnt low means dvld is ignored.
    // Arbitration is held off while a done pulse is out so the finished requester can drop req.
    assign arb_fire  = (state_q == S_IDLE) && wready && (req0 || req1) && !req0_done && !req1_done;
    assign arb_pick  = (req0 && req1) ? ~last_q : req1;
    assign pick_len  = arb_pick ? req1_len : req0_len;
    assign pick_addr = arb_pick ? req1_addr : req0_addr;
    assign own_dvld  = owner_q ? req1_dvld : req0_dvld;
    assign own_data  = owner_q ? req1_data : req0_data;
    assign accept    = (req0_gnt || req1_gnt) && own_dvld;
    assign cnt_inc   = cnt_q + LEN_WIDTH'(1);
    assign last_beat = accept && (cnt_inc == len_q);
    assign timeout   = (state_q == S_DATA) && !accept && (wd_q == WD_LAST);
    assign pad_last  = (state_q == S_PAD) && (cnt_inc == len_q);
    assign dbg_state = state_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:  if (arb_fire && pick_len != '0) state_d = S_START;
            S_START: state_d = last_beat ? S_IDLE : S_DATA;
            S_DATA: begin
                if (last_beat) begin
                    state_d = S_IDLE;
                end else if (timeout) begin
                    state_d = S_PAD;
                end
            end
            S_PAD:   if (pad_last) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // last_q remembers who was served last; resetting it to 1 gives req0 the first turn.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            owner_q   <= 1'b0;
            last_q    <= 1'b1;
            len_q     <= '0;
            cnt_q     <= '0;
            wd_q      <= '0;
            req0_gnt  <= 1'b0;
            req1_gnt  <= 1'b0;
            req0_done <= 1'b0;
            req1_done <= 1'b0;
            wstart    <= 1'b0;
            waddr     <= '0;
            wdata_len <= '0;
            wdata_vld <= 1'b0;
            wdata     <= '0;
            abort     <= 1'b0;
        end else begin
            wstart    <= 1'b0;
            req0_done <= 1'b0;
            req1_done <= 1'b0;
            abort     <= 1'b0;
            wdata_vld <= 1'b0;
            unique case (state_q)
                S_IDLE: begin
                    if (arb_fire) begin
                        owner_q <= arb_pick;
                        len_q   <= pick_len;
                        cnt_q   <= '0;
                        wd_q    <= '0;
                        if (pick_len == '0) begin
                            req0_done <= ~arb_pick;
                            req1_done <= arb_pick;
                            last_q    <= arb_pick;
                        end else begin
                            wstart    <= 1'b1;
                            waddr     <= pick_addr;
                            wdata_len <= pick_len;
                            req0_gnt  <= ~arb_pick;
                            req1_gnt  <= arb_pick;
                        end
                    end
                end
                S_START, S_DATA: begin
                    if (accept) begin
                        wdata_vld <= 1'b1;
                        wdata     <= own_data;
                        cnt_q     <= cnt_inc;
                        wd_q      <= '0;
                        if (last_beat) begin
                            req0_gnt  <= 1'b0;
                            req1_gnt  <= 1'b0;
                            req0_done <= ~owner_q;
                            req1_done <= owner_q;
                            last_q    <= owner_q;
                        end
                    end else if (state_q == S_DATA) begin
                        if (timeout) begin
                            abort    <= 1'b1;
                            req0_gnt <= 1'b0;
                            req1_gnt <= 1'b0;
                        end else begin
                            wd_q <= wd_q + WD_W'(1);
                        end
                    end
                end
                S_PAD: begin
                    wdata_vld <= 1'b1;
                    wdata     <= '0;
                    cnt_q     <= cnt_inc;
                    if (pad_last) begin
                        req0_done <= ~owner_q;
                        req1_done <= owner_q;
                        last_q    <= owner_q;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_ddr_wr_arbiter.sv
// Directed plus randomized bench for ddr_wr_arbiter: requester drivers, an output monitor
// and a burst-level reference model (grant order, command stream, beat stream, done order).
module tb_ddr_wr_arbiter;

    localparam int TO = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req   [2];
    logic [31:0] raddr [2];
    logic [15:0] rlen  [2];
    logic        rdvld [2];
    logic [63:0] rdata [2];
    logic        gnt0, gnt1, done0, done1;
    logic        wstart, wready, wdata_vld, abort;
    logic [31:0] waddr;
    logic [15:0] wdata_len;
    logic [63:0] wdata;
    logic [1:0]  dbg_state;

    ddr_wr_arbiter #(.DATA_WIDTH(64), .ADDR_WIDTH(32), .LEN_WIDTH(16), .TIMEOUT_CYC(TO)) dut (
        .clk(clk), .rst(rst),
        .req0(req[0]), .req0_addr(raddr[0]), .req0_len(rlen[0]), .req0_gnt(gnt0),
        .req0_dvld(rdvld[0]), .req0_data(rdata[0]), .req0_done(done0),
        .req1(req[1]), .req1_addr(raddr[1]), .req1_len(rlen[1]), .req1_gnt(gnt1),
        .req1_dvld(rdvld[1]), .req1_data(rdata[1]), .req1_done(done1),
        .wstart(wstart), .wready(wready), .waddr(waddr), .wdata_len(wdata_len),
        .wdata_vld(wdata_vld), .wdata(wdata), .abort(abort), .dbg_state(dbg_state)
    );

    // clock / reset
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL global_timeout: observed no finish, expected finish before 500us");
        $fatal(1);
    end

    // scoreboard state
    int n_cmp = 0;
    int n_err = 0;
    logic [63:0] exp_q[$], obs_q[$];
    int          exp_t_q[$], obs_t_q[$];
    logic [48:0] exp_cmd_q[$], cmd_q[$];
    int          exp_done_q[$], done_q[$];
    bit          rr_last = 1'b1;

    int   abort_cnt = 0, abort_cyc = 0, gnt_both = 0, wstart_bad = 0, done_total = 0, wstart_cyc = 0;
    int   done_cyc [2];
    logic wready_prev = 1'b0;

    // driver knobs
    int          sent [2];
    int          stop_after [2];
    int          pat_idx [2];
    logic [15:0] pat [2];
    bit          noise [2];
    bit          pat_mode = 1'b0;
    bit          wready_rand = 1'b0;
    int          gap_pct = 0;

    always @(negedge clk) begin
        if (rst) begin
            wready_prev = 1'b0;
        end else begin
            if (wdata_vld) begin
                obs_q.push_back(wdata);
                obs_t_q.push_back(cyc);
            end
            if (wstart) begin
                cmd_q.push_back({gnt1, waddr, wdata_len});
                wstart_cyc = cyc;
                if (!wready_prev) wstart_bad++;
            end
            if (done0) begin done_q.push_back(0); done_cyc[0] = cyc; done_total++; end
            if (done1) begin done_q.push_back(1); done_cyc[1] = cyc; done_total++; end
            if (abort) begin abort_cnt++; abort_cyc = cyc; end
            if (gnt0 && gnt1) gnt_both++;
            wready_prev = wready;
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic start_req(input int n, input logic [31:0] a, input logic [15:0] l, input int stop);
        raddr[n]      = a;
        rlen[n]       = l;
        req[n]        = 1'b1;
        sent[n]       = 0;
        stop_after[n] = stop;
        pat_idx[n]    = 0;
    endtask

    // Reference model: round-robin order of the pending set, one command per non-empty
    // burst, one done per burst in service order.
    task automatic plan();
        int order[$];
        if (req[0] && req[1]) begin
            order.push_back(rr_last ? 0 : 1);
            order.push_back(rr_last ? 1 : 0);
        end else if (req[0]) begin
            order.push_back(0);
        end else if (req[1]) begin
            order.push_back(1);
        end
        foreach (order[i]) begin
            int n;
            n = order[i];
            if (rlen[n] != 16'd0) exp_cmd_q.push_back({n[0], raddr[n], rlen[n]});
            exp_done_q.push_back(n);
            rr_last = n[0];
        end
    endtask

    // Requester behaviour: present beats while granted, drop req on done, and on done
    // expect the unsent remainder of the burst as zero beats.
    task automatic serve(input int budget, input int stop_beats);
        int n_cyc;
        bit g, d, v;
        n_cyc = 0;
        while ((req[0] || req[1]) && n_cyc < budget) begin
            @(posedge clk);
            #1;
            n_cyc++;
            if (wready_rand) wready = ($urandom_range(0, 3) != 0);
            for (int n = 0; n < 2; n++) begin
                g = (n == 0) ? gnt0 : gnt1;
                d = (n == 0) ? done0 : done1;
                rdvld[n] = 1'b0;
                if (req[n] && d) begin
                    req[n] = 1'b0;
                    for (int k = sent[n]; k < int'(rlen[n]); k++) begin
                        exp_q.push_back(64'd0);
                        exp_t_q.push_back(-1);
                    end
                end else if (req[n] && g) begin
                    if (sent[n] < stop_after[n]) begin
                        if (pat_mode) begin
                            v = pat[n][pat_idx[n]];
                            pat_idx[n]++;
                        end else begin
                            v = ($urandom_range(0, 99) >= gap_pct);
                        end
                        if (v) begin
                            rdvld[n] = 1'b1;
                            rdata[n] = {$urandom, $urandom};
                            exp_q.push_back(rdata[n]);
                            exp_t_q.push_back(cyc + 1);
                            sent[n]++;
                        end
                    end
                end else if (noise[n]) begin
                    rdvld[n] = 1'($urandom_range(0, 1));
                    rdata[n] = {$urandom, $urandom};
                end
            end
            if (stop_beats >= 0 && sent[0] + sent[1] >= stop_beats) break;
        end
        if (stop_beats < 0) chk("serve_complete", {62'd0, req[1], req[0]}, 64'd0);
    endtask

    task automatic settle();
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic compare_step(input string nm);
        chk({nm, " cmd_count"}, cmd_q.size(), exp_cmd_q.size());
        for (int i = 0; i < cmd_q.size() && i < exp_cmd_q.size(); i++)
            chk({nm, " cmd"}, cmd_q[i], exp_cmd_q[i]);
        chk({nm, " beat_count"}, obs_q.size(), exp_q.size());
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
            chk({nm, " beat_data"}, obs_q[i], exp_q[i]);
            if (exp_t_q[i] >= 0) chk({nm, " beat_cycle"}, obs_t_q[i], exp_t_q[i]);
        end
        chk({nm, " done_count"}, done_q.size(), exp_done_q.size());
        for (int i = 0; i < done_q.size() && i < exp_done_q.size(); i++)
            chk({nm, " done_owner"}, done_q[i], exp_done_q[i]);
        cmd_q.delete(); exp_cmd_q.delete();
        obs_q.delete(); obs_t_q.delete();
        exp_q.delete(); exp_t_q.delete();
        done_q.delete(); exp_done_q.delete();
    endtask

    task automatic chk_outputs_zero(input string nm);
        chk({nm, " ctrl"}, {57'd0, gnt0, gnt1, done0, done1, wstart, wdata_vld, abort}, 64'd0);
        chk({nm, " waddr"}, waddr, 64'd0);
        chk({nm, " wdata_len"}, wdata_len, 64'd0);
        chk({nm, " wdata"}, wdata, 64'd0);
        chk({nm, " state"}, dbg_state, 64'd0);
    endtask

    initial begin
        int t_req, t_rel, d_before, mask;
        logic [15:0] l;
        for (int n = 0; n < 2; n++) begin
            req[n] = 1'b0; raddr[n] = '0; rlen[n] = '0; rdvld[n] = 1'b0; rdata[n] = '0;
            sent[n] = 0; stop_after[n] = 0; pat_idx[n] = 0; pat[n] = '0; noise[n] = 1'b0;
            done_cyc[n] = 0;
        end
        wready = 1'b1;

        // both requesters pending across reset: req0 wins, then req1
        start_req(0, 32'h0000_0200, 16'd2, 2);
        start_req(1, 32'h0000_0240, 16'd2, 2);
        #2 rst = 1'b1;
        #1;
        chk_outputs_zero("reset");
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        plan();
        serve(400, -1);
        settle();
        if (cmd_q.size() > 0) chk("t2 first_owner", cmd_q[0][48], 64'd0);
        compare_step("t2a");
        start_req(0, 32'h0000_0280, 16'd2, 2);
        start_req(1, 32'h0000_02c0, 16'd2, 2);
        plan();
        serve(400, -1);
        settle();
        if (cmd_q.size() > 0) chk("t2 reassert_first_owner", cmd_q[0][48], 64'd0);
        compare_step("t2b");

        // single burst, back-to-back beats
        start_req(0, 32'h0000_0100, 16'd4, 4);
        plan();
        serve(400, -1);
        settle();
        chk("t1 gnt0_low", gnt0, 64'd0);
        compare_step("t1");

        // zero-length burst, then a simultaneous pair
        start_req(1, 32'h0000_0000, 16'd0, 0);
        t_req = cyc;
        plan();
        serve(50, -1);
        settle();
        chk("t3 done_latency_ok", 64'((done_cyc[1] - t_req) <= 2), 64'd1);
        compare_step("t3a");
        start_req(0, 32'h0000_0300, 16'd2, 2);
        start_req(1, 32'h0000_0340, 16'd3, 3);
        plan();
        serve(400, -1);
        settle();
        if (cmd_q.size() > 0) chk("t3 first_owner", cmd_q[0][48], 64'd0);
        compare_step("t3b");

        // gapped beats, non-owner noise, wready held low at arbitration
        wready = 1'b0;
        pat_mode = 1'b1;
        pat[0] = 16'b0000_0000_0001_1001;
        noise[1] = 1'b1;
        start_req(0, 32'h0000_0400, 16'd3, 3);
        repeat (6) begin
            @(posedge clk);
            #1;
            rdvld[1] = 1'($urandom_range(0, 1));
            rdata[1] = {$urandom, $urandom};
        end
        chk("t4 no_wstart_while_not_ready", cmd_q.size(), 64'd0);
        t_rel = cyc;
        wready = 1'b1;
        plan();
        serve(400, -1);
        settle();
        chk("t4 wstart_after_ready", 64'(wstart_cyc > t_rel), 64'd1);
        compare_step("t4");
        pat_mode = 1'b0;
        noise[1] = 1'b0;
        rdvld[1] = 1'b0;

        // stalled burst: watchdog abort and zero padding
        start_req(1, 32'h0000_0500, 16'd8, 3);
        plan();
        serve(400, -1);
        settle();
        chk("t5 abort_count", abort_cnt, 64'd1);
        chk("t5 total_beats", obs_q.size(), 64'd8);
        if (obs_t_q.size() == 8) begin
            chk("t5 abort_delay", 64'(abort_cyc - obs_t_q[2]), 64'(TO));
            for (int i = 3; i < 8; i++) chk("t5 pad_cycle", obs_t_q[i], abort_cyc + i - 2);
        end
        compare_step("t5");

        // randomized bursts with random wready, gaps and non-owner noise
        for (int r = 0; r < 8; r++) begin
            gap_pct = 25;
            noise[0] = 1'b1;
            noise[1] = 1'b1;
            wready_rand = 1'b1;
            mask = $urandom_range(1, 3);
            for (int n = 0; n < 2; n++) begin
                if (mask[n]) begin
                    l = 16'($urandom_range(0, 6));
                    start_req(n, $urandom & 32'hffff_fff8, l, int'(l));
                end
            end
            plan();
            serve(2000, -1);
            wready_rand = 1'b0;
            wready = 1'b1;
            rdvld[0] = 1'b0;
            rdvld[1] = 1'b0;
            settle();
            compare_step("rand");
        end
        gap_pct = 0;
        noise[0] = 1'b0;
        noise[1] = 1'b0;

        // reset in the middle of a burst
        start_req(0, 32'h0000_0600, 16'd6, 6);
        exp_cmd_q.push_back({1'b0, 32'h0000_0600, 16'd6});
        serve(200, 2);
        @(posedge clk);
        #1;
        rdvld[0] = 1'b0;
        req[0] = 1'b0;
        @(negedge clk);
        #1;
        rst = 1'b1;
        #1;
        chk_outputs_zero("t6 midburst_reset");
        d_before = done_total;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        rr_last = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("t6 no_done_after_reset", done_total, d_before);
        compare_step("t6a");
        start_req(0, 32'h0000_0700, 16'd3, 3);
        plan();
        serve(400, -1);
        settle();
        compare_step("t6b");

        chk("grant_exclusive", gnt_both, 64'd0);
        chk("wstart_only_after_wready", wstart_bad, 64'd0);
        chk("abort_total", abort_cnt, 64'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
